// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV64F multi-cycle core front end:
//   - fetch/decode FSM state encodings (legacy-compatible localparams)
//   - RV opcode indices (insn[6:2]) used to address the one-hot code vector
//   - trap-cause encodings reported by the fetch/decode stage
// No ports; imported with "import core_pkg::*;".
// -----------------------------------------------------------------------------
package core_pkg;

  // Fetch/decode FSM states
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_EXEC = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT      = 3'd5;
  localparam logic [STATE_W-1:0] ST_TRAP      = 3'd6;

  // Opcode indices: insn[6:2] for 32-bit encodings (insn[1:0] == 2'b11)
  localparam logic [4:0] OPC_LOAD     = 5'd0;
  localparam logic [4:0] OPC_LOAD_FP  = 5'd1;
  localparam logic [4:0] OPC_OP_IMM   = 5'd4;
  localparam logic [4:0] OPC_AUIPC    = 5'd5;
  localparam logic [4:0] OPC_OP_IMM_W = 5'd6;
  localparam logic [4:0] OPC_STORE    = 5'd8;
  localparam logic [4:0] OPC_STORE_FP = 5'd9;
  localparam logic [4:0] OPC_OP       = 5'd12;
  localparam logic [4:0] OPC_LUI      = 5'd13;
  localparam logic [4:0] OPC_OP_W     = 5'd14;
  localparam logic [4:0] OPC_OP_FP    = 5'd20;
  localparam logic [4:0] OPC_BRANCH   = 5'd24;
  localparam logic [4:0] OPC_JALR     = 5'd25;
  localparam logic [4:0] OPC_JAL      = 5'd27;
  localparam logic [4:0] OPC_SYSTEM   = 5'd28;

  // Trap causes
  localparam logic [1:0] TRAP_NONE       = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL    = 2'b01;
  localparam logic [1:0] TRAP_MISALIGNED = 2'b10;

endpackage : core_pkg

// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational opcode decode: maps insn[6:2] to a one-hot 32-bit code
// vector. Anything without the 32-bit-encoding suffix (insn[1:0] != 11) is
// flagged illegal and decodes to an all-zero code.
// Ports:
//   insn_i     in  32  instruction word
//   code_o     out 32  one-hot opcode (1 << insn[6:2]), zero when illegal
//   illegal_o  out 1   insn[1:0] != 2'b11
// -----------------------------------------------------------------------------
module opcode_decoder (
  input  logic [31:0] insn_i,
  output logic [31:0] code_o,
  output logic        illegal_o
);

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally up front) so no latch is inferred.
  always_comb begin
    illegal_o = (insn_i[1:0] != 2'b11);
    code_o    = '0;
    if (!illegal_o) begin
      code_o = 32'd1 << insn_i[6:2];
    end
  end

endmodule : opcode_decoder

// File: rtl/fetch_decode_fsm.sv
// -----------------------------------------------------------------------------
// fetch_decode_fsm
// Front-end control stage of the multi-cycle RV64F core. Fetches the word at
// pc over a variable-latency imem handshake, decodes its opcode into a one-hot
// code, pulses start to the execute FSM and waits for exec_done. Misaligned
// fetches and illegal encodings trap; SYSTEM opcodes halt. Both are sticky
// until reset. Counts retired instructions.
// Ports:
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   run         in   1      level enable for starting a fetch
//   pc          in   XLEN   current program counter
//   imem_rdata  in   32     instruction word, valid with imem_done
//   imem_done   in   1      memory completion pulse
//   exec_done   in   1      execute completion pulse
//   imem_start  out  1      memory request, held while in FETCH
//   imem_addr   out  XLEN   registered fetch address
//   insn        out  32     latched instruction
//   code        out  32     one-hot decoded opcode
//   start       out  1      one-cycle issue pulse
//   busy        out  1      not in IDLE/HALT/TRAP
//   halted      out  1      SYSTEM opcode reached
//   trap        out  1      illegal or misaligned fetch
//   trap_cause  out  2      01 illegal, 10 misaligned, 00 none
//   retired     out  CNT_W  completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_decode_fsm
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_done,
  input  logic             exec_done,
  output logic             imem_start,
  output logic [XLEN-1:0]  imem_addr,
  output logic [31:0]      insn,
  output logic [31:0]      code,
  output logic             start,
  output logic             busy,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [31:0]        insn_q, insn_d;
  logic [31:0]        code_q, code_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [31:0] dec_code;
  logic        dec_illegal;

  // Decode always looks at the latched word, so DECODE sees a stable input
  // regardless of what imem_rdata does after the handshake.
  opcode_decoder u_dec (
    .insn_i    (insn_q),
    .code_o    (dec_code),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    insn_d    = insn_q;
    code_d    = code_q;
    cause_d   = cause_q;
    retired_d = retired_q;

    case (state_q)
      ST_IDLE: begin
        // pc is sampled here, one cycle after exec_done, so the datapath's
        // pc update for the previous instruction is already visible.
        if (run) begin
          if (pc[1:0] != 2'b00) begin
            state_d = ST_TRAP;
            cause_d = TRAP_MISALIGNED;
          end else begin
            state_d = ST_FETCH;
            addr_d  = pc;
          end
        end
      end

      ST_FETCH: begin
        if (imem_done) begin
          insn_d  = imem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // dec_code is already zero for an illegal encoding; a SYSTEM opcode
        // still publishes its code bit before halting.
        code_d = dec_code;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else if (insn_q[6:2] == OPC_SYSTEM) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: state_d = ST_WAIT_EXEC;

      ST_WAIT_EXEC: begin
        // run is not consulted here: a started instruction always completes,
        // and IDLE decides whether to refetch.
        if (exec_done) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end

      ST_HALT, ST_TRAP: state_d = state_q;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      insn_q    <= '0;
      code_q    <= '0;
      cause_q   <= TRAP_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      insn_q    <= insn_d;
      code_q    <= code_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // All outputs come from registers or from state decode only.
  assign imem_start = (state_q == ST_FETCH);
  assign imem_addr  = addr_q;
  assign insn       = insn_q;
  assign code       = code_q;
  assign start      = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT) &&
                      (state_q != ST_TRAP);
  assign halted     = (state_q == ST_HALT);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule : fetch_decode_fsm

// File: tb/tb_fetch_decode_fsm.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_fsm
// Directed bench for fetch_decode_fsm: a scripted instruction memory and
// execute stage, with hand-computed expected codes, causes and counts.
// -----------------------------------------------------------------------------
module tb_fetch_decode_fsm;

  localparam int XLEN  = 64;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [XLEN-1:0]  pc;
  logic [31:0]      imem_rdata;
  logic             imem_done;
  logic             exec_done;
  logic             imem_start;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      insn;
  logic [31:0]      code;
  logic             start;
  logic             busy;
  logic             halted;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;

  fetch_decode_fsm #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .pc         (pc),
    .imem_rdata (imem_rdata),
    .imem_done  (imem_done),
    .exec_done  (exec_done),
    .imem_start (imem_start),
    .imem_addr  (imem_addr),
    .insn       (insn),
    .code       (code),
    .start      (start),
    .busy       (busy),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    run        = 1'b0;
    imem_done  = 1'b0;
    exec_done  = 1'b0;
    imem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Entered in FETCH. Answers on the lat-th request cycle; leaves in DECODE.
  task automatic fetch(input int lat, input logic [31:0] word,
                       output int reqs, output bit addr_ok,
                       output logic [XLEN-1:0] addr0);
    reqs    = 0;
    addr_ok = 1'b1;
    addr0   = imem_addr;
    for (int k = 1; k <= lat; k++) begin
      if (imem_start === 1'b1) reqs++;
      if (imem_addr !== addr0) addr_ok = 1'b0;
      if (k == lat) begin
        imem_done  = 1'b1;
        imem_rdata = word;
      end
      tick();
      imem_done = 1'b0;
    end
  endtask

  // Entered in DECODE of a legal non-SYSTEM insn. exec_done (with the new pc)
  // arrives exec_lat cycles after ISSUE; leaves in IDLE.
  task automatic finish_insn(input int exec_lat, input bit drop_run,
                             input logic [XLEN-1:0] next_pc,
                             output int starts);
    starts = 0;
    if (drop_run) run = 1'b0;
    tick();
    for (int k = 0; k <= exec_lat; k++) begin
      if (start === 1'b1) starts++;
      if (k == exec_lat) begin
        exec_done = 1'b1;
        pc        = next_pc;
      end
      tick();
      exec_done = 1'b0;
    end
  endtask

  task automatic watch(input int n, output int starts, output int reqs);
    starts = 0;
    reqs   = 0;
    for (int k = 0; k < n; k++) begin
      if (start === 1'b1) starts++;
      if (imem_start === 1'b1) reqs++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (insn !== 32'h0) begin bad++; $display("FAIL rst_insn: got %h want 0", insn); end
    total++; if (code !== 32'h0) begin bad++; $display("FAIL rst_code: got %h want 0", code); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL rst_retired: got %0d want 0", retired); end
    total++; if (trap_cause !== 2'b00) begin bad++; $display("FAIL rst_cause: got %b want 00", trap_cause); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    total++;
    if ({imem_start, start, busy, halted, trap} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b want 00000", {imem_start, start, busy, halted, trap});
    end
  endtask

  task automatic test_addi();
    int reqs, starts;
    bit aok;
    logic [XLEN-1:0] a0;
    do_reset();
    pc  = 64'h0;
    run = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL addi_busy: got %b want 1", busy); end
    fetch(1, 32'h00A0_0093, reqs, aok, a0);
    total++; if (reqs !== 1) begin bad++; $display("FAIL addi_reqs: got %0d want 1", reqs); end
    total++; if (insn !== 32'h00A0_0093) begin bad++; $display("FAIL addi_insn: got %h want 00a00093", insn); end
    finish_insn(1, 1'b1, 64'h4, starts);
    total++; if (code !== 32'h0000_0010) begin bad++; $display("FAIL addi_code: got %h want 00000010", code); end
    total++; if (starts !== 1) begin bad++; $display("FAIL addi_starts: got %0d want 1", starts); end
    total++; if (retired !== 64'd1) begin bad++; $display("FAIL addi_retired: got %0d want 1", retired); end
    watch(4, starts, reqs);
    total++; if (starts + reqs !== 0) begin bad++; $display("FAIL addi_idle: got %0d activity want 0", starts + reqs); end
  endtask

  task automatic test_jal_latency();
    int reqs, starts;
    bit aok;
    logic [XLEN-1:0] a0;
    do_reset();
    pc  = 64'h40;
    run = 1'b1;
    tick();
    fetch(5, 32'h0000_006F, reqs, aok, a0);
    total++; if (reqs !== 5) begin bad++; $display("FAIL jal_reqs: got %0d want 5", reqs); end
    total++; if (!aok || a0 !== 64'h40) begin bad++; $display("FAIL jal_addr: got %h stable=%b want 40", a0, aok); end
    total++; if (imem_start !== 1'b0) begin bad++; $display("FAIL jal_req_drop: got %b want 0", imem_start); end
    finish_insn(2, 1'b1, 64'h44, starts);
    total++; if (code !== 32'h0800_0000) begin bad++; $display("FAIL jal_code: got %h want 08000000", code); end
    total++; if (starts !== 1) begin bad++; $display("FAIL jal_starts: got %0d want 1", starts); end
  endtask

  task automatic test_misaligned();
    int reqs, starts;
    do_reset();
    pc  = 64'h102;
    run = 1'b1;
    tick();
    total++; if (trap !== 1'b1 || trap_cause !== 2'b10) begin bad++; $display("FAIL mis_trap: got %b/%b want 1/10", trap, trap_cause); end
    watch(6, starts, reqs);
    total++; if (reqs !== 0 || starts !== 0) begin bad++; $display("FAIL mis_quiet: got reqs=%0d starts=%0d want 0/0", reqs, starts); end
    total++;
    if (trap !== 1'b1 || trap_cause !== 2'b10 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mis_sticky: got trap=%b cause=%b busy=%b want 1/10/0", trap, trap_cause, busy);
    end
    do_reset();
    total++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin bad++; $display("FAIL mis_clear: got %b/%b want 0/00", trap, trap_cause); end
  endtask

  task automatic test_illegal();
    int reqs, starts;
    bit aok;
    logic [XLEN-1:0] a0;
    do_reset();
    pc  = 64'h0;
    run = 1'b1;
    tick();
    fetch(1, 32'h00A0_0093, reqs, aok, a0);
    finish_insn(1, 1'b1, 64'h4, starts);
    run = 1'b1;
    tick();
    fetch(2, 32'h0000_0000, reqs, aok, a0);
    watch(6, starts, reqs);
    total++; if (starts !== 0) begin bad++; $display("FAIL ill_starts: got %0d want 0", starts); end
    total++; if (trap !== 1'b1 || trap_cause !== 2'b01) begin bad++; $display("FAIL ill_trap: got %b/%b want 1/01", trap, trap_cause); end
    total++; if (code !== 32'h0) begin bad++; $display("FAIL ill_code: got %h want 0", code); end
  endtask

  task automatic test_back_to_back_and_halt();
    int reqs, starts, sum_starts;
    bit aok;
    logic [XLEN-1:0] a0;
    logic [31:0] words [3];
    logic [31:0] codes [3];
    words = '{32'h00A0_0093, 32'h0020_81B3, 32'h1234_52B7};
    codes = '{32'h0000_0010, 32'h0000_1000, 32'h0000_2000};
    sum_starts = 0;
    do_reset();
    pc  = 64'h0;
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch(1 + i, words[i], reqs, aok, a0);
      total++; if (a0 !== 64'(4 * i)) begin bad++; $display("FAIL b2b_addr%0d: got %h want %h", i, a0, 64'(4 * i)); end
      finish_insn(1, (i == 2), 64'(4 * (i + 1)), starts);
      sum_starts += starts;
      total++; if (code !== codes[i]) begin bad++; $display("FAIL b2b_code%0d: got %h want %h", i, code, codes[i]); end
      if (i < 2) tick();
    end
    total++; if (retired !== 64'd3) begin bad++; $display("FAIL b2b_retired: got %0d want 3", retired); end
    total++; if (sum_starts !== 3) begin bad++; $display("FAIL b2b_starts: got %0d want 3", sum_starts); end
    watch(5, starts, reqs);
    total++; if (reqs !== 0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: got reqs=%0d busy=%b want 0/0", reqs, busy); end

    // ecall at pc 12 after three retirements
    run = 1'b1;
    tick();
    fetch(1, 32'h0000_0073, reqs, aok, a0);
    watch(6, starts, reqs);
    total++; if (starts !== 0) begin bad++; $display("FAIL ecall_starts: got %0d want 0", starts); end
    total++; if (halted !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ecall_halt: got halted=%b busy=%b want 1/0", halted, busy); end
    total++; if (code !== 32'h1000_0000) begin bad++; $display("FAIL ecall_code: got %h want 10000000", code); end
    total++; if (retired !== 64'd3) begin bad++; $display("FAIL ecall_retired: got %0d want 3", retired); end
  endtask

  task automatic test_reset_mid_fetch();
    int reqs, starts;
    bit aok;
    logic [XLEN-1:0] a0;
    do_reset();
    pc  = 64'h0;
    run = 1'b1;
    tick();
    fetch(1, 32'h00A0_0093, reqs, aok, a0);
    finish_insn(1, 1'b1, 64'h4, starts);
    run = 1'b1;
    tick();
    total++; if (imem_start !== 1'b1) begin bad++; $display("FAIL rmf_fetching: got %b want 1", imem_start); end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    run        = 1'b0;
    imem_done  = 1'b1;
    imem_rdata = 32'h0000_006F;
    exec_done  = 1'b1;
    tick();
    imem_done = 1'b0;
    exec_done = 1'b0;
    total++; if (insn !== 32'h0 || code !== 32'h0) begin bad++; $display("FAIL rmf_insn: got %h/%h want 0/0", insn, code); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL rmf_retired: got %0d want 0", retired); end
    watch(5, starts, reqs);
    total++; if (starts !== 0 || reqs !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rmf_idle: got starts=%0d reqs=%0d busy=%b want 0/0/0", starts, reqs, busy); end
  endtask

  initial begin
    reset      = 1'b1;
    run        = 1'b0;
    pc         = '0;
    imem_rdata = '0;
    imem_done  = 1'b0;
    exec_done  = 1'b0;
    test_reset();
    test_addi();
    test_jal_latency();
    test_misaligned();
    test_illegal();
    test_back_to_back_and_halt();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_decode_fsm

// File: doc/fetch_decode_fsm.md
Name: fetch_decode_fsm

Overview:
- Front-end control stage of the multi-cycle RV64F core; sits directly upstream of the execute FSM.
- Fetches the 32-bit instruction at the current PC through a variable-latency instruction-memory handshake, then latches it.
- Decodes the opcode into the one-hot `code` vector and pulses `start` to the execute FSM.
- Waits for execute completion, then begins the next fetch. Also flags illegal or misaligned fetches and SYSTEM-opcode halts, and counts retired instructions.

Parameters:
- XLEN, 64, PC/address width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level enable; fetching begins or continues only while high
- pc  in  XLEN  current program counter (register owned by the datapath)
- imem_rdata  in  32  instruction word from memory
- imem_done  in  1  one-cycle pulse; imem_rdata valid in the same cycle
- exec_done  in  1  one-cycle pulse from execute FSM on instruction completion
- imem_start  out  1  memory request, held high while waiting
- imem_addr  out  XLEN  fetch address
- insn  out  32  latched instruction
- code  out  32  one-hot decoded opcode
- start  out  1  one-cycle pulse to execute FSM
- busy  out  1  high in every state except IDLE/HALT/TRAP
- halted  out  1  SYSTEM opcode reached
- trap  out  1  illegal or misaligned fetch
- trap_cause  out  2  01 illegal opcode, 10 misaligned PC, 00 none
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: state IDLE; insn = 0, code = 0, retired = 0, trap_cause = 00. All single-bit outputs 0; imem_addr = 0. Reset has priority over every event and aborts any in-flight operation in one cycle; any late imem_done or exec_done is ignored.
- IDLE:
  - If run is low, stay in IDLE.
  - If run is high and pc[1:0] != 00, go to TRAP with cause 10.
  - Otherwise go to FETCH and register imem_addr = pc.
- FETCH:
  - imem_start = 1 and imem_addr stays stable.
  - On imem_done, latch insn = imem_rdata and go to DECODE.
  - The stage waits indefinitely; there is no timeout.
- DECODE (1 cycle):
  - If insn[1:0] != 11, code = 0 and go to TRAP with cause 01.
  - Otherwise code = 1 << insn[6:2].
  - If insn[6:2] == 11100 (SYSTEM, ecall/ebreak), code is still written; go to HALT without issuing.
  - Any other value of insn[6:2] goes to ISSUE. Opcode legality beyond the 11 suffix is the execute stage's concern.
- ISSUE (1 cycle): start = 1, then go to WAIT_EXEC. insn and code stay stable from DECODE until the next DECODE.
- WAIT_EXEC:
  - On exec_done, retired += 1, wrapping modulo 2^CNT_W.
  - If run is high, go to IDLE and refetch next cycle. The PC update lands the same cycle as exec_done, so IDLE samples the new pc.
  - If run is low, go to IDLE and stop.
  - A run deassert mid-instruction does not abort it.
- HALT: halted = 1; sticky until reset.
- TRAP: trap = 1 and trap_cause held; sticky until reset.
- Fetch-to-start latency with a single-cycle memory: IDLE → FETCH (done in cycle 1) → DECODE → ISSUE, so start rises 3 cycles after leaving IDLE.
- A spurious exec_done outside WAIT_EXEC and a spurious imem_done outside FETCH are ignored.
- Outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package `core_pkg` holds:
  - state localparams;
  - opcode-index constants OPC_LOAD=0, OPC_LOAD_FP=1, OPC_OP_IMM=4, OPC_AUIPC=5, OPC_OP_IMM_W=6, OPC_STORE=8, OPC_STORE_FP=9, OPC_OP=12, OPC_LUI=13, OPC_OP_W=14, OPC_OP_FP=20, OPC_BRANCH=24, OPC_JALR=25, OPC_JAL=27, OPC_SYSTEM=28;
  - trap-cause constants.
- One sub-module, `opcode_decoder`: combinational insn → {code, illegal}. It is reused by test benches as the golden decode.

Test Plan:
- Reset then run=1, pc=0x0, imem_done same cycle with 0x00A00093 (addi) → code = 0x10 (bit 4); start pulses exactly once; after exec_done, retired = 1.
- Memory latency 5 cycles, insn 0x0000006F (jal) → imem_start high for 5 cycles with imem_addr stable; code = 0x08000000.
- pc = 0x102 with run=1 → no imem_start; trap = 1, trap_cause = 10; stays until reset.
- insn 0x00000000 → trap_cause = 01, code = 0, start never pulses.
- insn 0x00000073 (ecall) → halted = 1, code = 0x10000000, start never pulses; retired unchanged.
- Reset asserted during FETCH with imem_done arriving next cycle → state IDLE; insn = 0, start stays 0. Also: three back-to-back instructions → retired = 3, with run dropped during the third instruction completing it and then idling.
